// File: rtl/drum_pkg.sv
// Shared types and constants for the drum membrane column scheduler.
// Node values are 18-bit signed; intermediate sums are carried at 21 bits.
package drum_pkg;

    localparam int NODE_W = 18;
    localparam int WIDE_W = 21;

    localparam int LAP_SHIFT  = 4;
    localparam int DAMP_SHIFT = 12;
    localparam int LOSS_SHIFT = 13;

    typedef logic signed [NODE_W-1:0] node_t;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME0,
        PRIME1,
        RUN,
        DONE
    } state_t;

    function automatic wide_t widen(input node_t v);
        return {{(WIDE_W-NODE_W){v[NODE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/drum_node_update.sv
// Combinational finite-difference update for one membrane node.
// Each stage truncates back to 18 bits, so overflow wraps rather than saturates.
module drum_node_update
    import drum_pkg::*;
(
    input  logic signed [17:0] l,
    input  logic signed [17:0] r,
    input  logic signed [17:0] u,
    input  logic signed [17:0] d,
    input  logic signed [17:0] c,
    input  logic signed [17:0] p,
    output logic signed [17:0] next
);

    wide_t sum;
    wide_t lap_w;
    wide_t damp;
    wide_t t_w;
    node_t lap;
    node_t t;

    always_comb begin
        sum   = widen(l) + widen(r) + widen(u) + widen(d)
              - (widen(c) <<< 2);
        lap_w = sum >>> LAP_SHIFT;
        lap   = lap_w[NODE_W-1:0];
        // P - P/4096: a mild damping of the previous-step value
        damp  = widen(p) - (widen(p) >>> DAMP_SHIFT);
        t_w   = widen(lap) + (widen(c) <<< 1) - damp;
        t     = t_w[NODE_W-1:0];
        next  = t - (t >>> LOSS_SHIFT);
    end

endmodule

// File: rtl/drum_column_sched.sv
// Steps one column of the drum mesh, one row per cycle, over two node banks.
// A three-entry window (D, C, U) slides down the column fed by 1-cycle reads.
module drum_column_sched
    import drum_pkg::*;
#(
    parameter int N_ROWS = 32,
    parameter int AW     = 5
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    output logic [AW-1:0]        row_idx,
    input  logic signed [17:0]   left_u,
    input  logic signed [17:0]   right_u,
    input  logic                 init_wr_en,
    input  logic [AW-1:0]        init_addr,
    input  logic signed [17:0]   init_data,
    output logic                 init_ready,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [17:0]   cur_rd_data,
    input  logic signed [17:0]   prev_rd_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [17:0]   cur_wr_data,
    output logic signed [17:0]   prev_wr_data,
    output logic signed [17:0]   mid_u
);

    localparam logic [AW-1:0] LAST = AW'(N_ROWS - 1);
    localparam logic [AW-1:0] NEAR = AW'(N_ROWS - 3);
    localparam logic [AW-1:0] MID  = AW'(N_ROWS / 2);

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] row_q;
    logic [AW-1:0] row_d;
    node_t         c_q;
    node_t         d_q;
    node_t         p_q;
    node_t         mid_q;
    node_t         op_u;
    node_t         op_d;
    node_t         next;

    assign row_idx = row_q;
    assign mid_u   = mid_q;

    // Edge rows see a clamped zero neighbour, never memory data.
    assign op_u = (row_q == LAST) ? '0 : cur_rd_data;
    assign op_d = (row_q == '0)   ? '0 : d_q;

    drum_node_update u_node (
        .l    (left_u),
        .r    (right_u),
        .u    (op_u),
        .d    (op_d),
        .c    (c_q),
        .p    (p_q),
        .next (next)
    );

    always_comb begin
        state_d      = state;
        row_d        = row_q;
        busy         = 1'b0;
        step_done    = 1'b0;
        init_ready   = 1'b0;
        rd_addr      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        cur_wr_data  = '0;
        prev_wr_data = '0;
        unique case (state)
            IDLE: begin
                init_ready = 1'b1;
                row_d      = '0;
                if (step_start) begin
                    state_d = PRIME0;
                end else if (init_wr_en) begin
                    wr_en        = 1'b1;
                    wr_addr      = init_addr;
                    cur_wr_data  = init_data;
                    prev_wr_data = init_data;
                end
            end
            PRIME0: begin
                busy    = 1'b1;
                rd_addr = '0;
                state_d = PRIME1;
            end
            PRIME1: begin
                busy    = 1'b1;
                rd_addr = AW'(1);
                state_d = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                rd_addr      = (row_q >= NEAR) ? LAST : row_q + AW'(2);
                wr_en        = 1'b1;
                wr_addr      = row_q;
                cur_wr_data  = next;
                prev_wr_data = c_q;
                if (row_q == LAST) begin
                    state_d = DONE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + AW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                step_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row_q <= '0;
            c_q   <= '0;
            d_q   <= '0;
            p_q   <= '0;
            mid_q <= '0;
        end else begin
            state <= state_d;
            row_q <= row_d;
            if (state == PRIME1) begin
                c_q <= cur_rd_data;
                p_q <= prev_rd_data;
                d_q <= '0;
            end else if (state == RUN) begin
                d_q <= c_q;
                c_q <= cur_rd_data;
                p_q <= prev_rd_data;
                if (row_q == MID) begin
                    mid_q <= next;
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_column_sched.sv
// Directed bench for drum_column_sched with a 4-row column and modelled banks.
module tb_drum_column_sched;

    localparam int N = 4;
    localparam int A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                step_start;
    logic                busy;
    logic                step_done;
    logic [A-1:0]        row_idx;
    logic signed [17:0]  left_u;
    logic signed [17:0]  right_u;
    logic                init_wr_en;
    logic [A-1:0]        init_addr;
    logic signed [17:0]  init_data;
    logic                init_ready;
    logic [A-1:0]        rd_addr;
    logic signed [17:0]  cur_rd_data;
    logic signed [17:0]  prev_rd_data;
    logic                wr_en;
    logic [A-1:0]        wr_addr;
    logic signed [17:0]  cur_wr_data;
    logic signed [17:0]  prev_wr_data;
    logic signed [17:0]  mid_u;

    drum_column_sched #(.N_ROWS(N), .AW(A)) dut (
        .clk          (clk),
        .rst          (rst),
        .step_start   (step_start),
        .busy         (busy),
        .step_done    (step_done),
        .row_idx      (row_idx),
        .left_u       (left_u),
        .right_u      (right_u),
        .init_wr_en   (init_wr_en),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .init_ready   (init_ready),
        .rd_addr      (rd_addr),
        .cur_rd_data  (cur_rd_data),
        .prev_rd_data (prev_rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .cur_wr_data  (cur_wr_data),
        .prev_wr_data (prev_wr_data),
        .mid_u        (mid_u)
    );

    logic signed [17:0] cur_mem  [N];
    logic signed [17:0] prev_mem [N];
    logic signed [17:0] pre_cur  [N];
    logic signed [17:0] pre_prev [N];
    logic               pre_en;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < N; i++) begin
                cur_mem[i]  <= pre_cur[i];
                prev_mem[i] <= pre_prev[i];
            end
        end else if (wr_en) begin
            cur_mem[wr_addr]  <= cur_wr_data;
            prev_mem[wr_addr] <= prev_wr_data;
        end
        cur_rd_data  <= cur_mem[rd_addr];
        prev_rd_data <= prev_mem[rd_addr];
    end

    int ntest = 0;
    int nfail = 0;
    int nw;
    int nd;
    int done_at;
    int kc;

    logic [A-1:0]       wa [16];
    logic signed [17:0] wc [16];
    logic signed [17:0] wp [16];
    logic               busy_at [24];
    logic               wr_at   [24];
    logic               rdy_at  [24];
    logic [A-1:0]       rd_at   [24];
    logic [A-1:0]       row_at  [24];

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        ntest++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (wr_en && nw < 16) begin
            wa[nw] = wr_addr;
            wc[nw] = cur_wr_data;
            wp[nw] = prev_wr_data;
            nw++;
        end
        if (step_done) begin
            nd++;
            if (done_at < 0) done_at = kc;
        end
        if (kc < 24) begin
            busy_at[kc] = busy;
            wr_at[kc]   = wr_en;
            rdy_at[kc]  = init_ready;
            rd_at[kc]   = rd_addr;
            row_at[kc]  = row_idx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic signed [17:0] v);
        for (int i = 0; i < N; i++) begin
            pre_cur[i]  = '0;
            pre_prev[i] = '0;
        end
        pre_cur[idx] = v;
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic run_step(input int repulse_k, input int rst_k,
                            input logic with_init);
        nw = 0;
        nd = 0;
        done_at = -1;
        step_start = 1'b1;
        if (with_init) begin
            init_wr_en = 1'b1;
            init_addr  = 2'd3;
            init_data  = 18'sd999;
        end
        kc = 0;
        cyc();
        step_start = 1'b0;
        init_wr_en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            kc = k;
            cyc();
            step_start = (k == repulse_k);
            rst        = (k == rst_k);
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        step_start = 1'b0;
        left_u     = '0;
        right_u    = '0;
        init_wr_en = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        pre_en     = 1'b0;
        kc         = 99;
        nw         = 0;
        nd         = 0;
        done_at    = -1;
        preload(0, 18'sd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", step_done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_row", row_idx, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_mid_u", mid_u, 0);
        chk("rst_init_ready", init_ready, 1);

        // host init write passes straight through to both banks
        @(posedge clk);
        #1;
        init_wr_en = 1'b1;
        init_addr  = 2'd2;
        init_data  = -18'sd5;
        @(negedge clk);
        chk("init_wr_en", wr_en, 1);
        chk("init_wr_addr", wr_addr, 2);
        chk("init_cur", cur_wr_data, -5);
        chk("init_prev", prev_wr_data, -5);
        @(posedge clk);
        #1;
        init_wr_en = 1'b0;
        @(negedge clk);
        chk("init_bank_cur", cur_mem[2], -5);
        chk("init_bank_prev", prev_mem[2], -5);
        @(posedge clk);
        #1;

        // all-zero banks: four zero writes, done on cycle 7
        preload(0, 18'sd0);
        run_step(0, 0, 1'b0);
        chk("zero_nw", nw, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("zero_addr%0d", i), wa[i], i);
            chk($sformatf("zero_cur%0d", i), wc[i], 0);
        end
        chk("zero_done_at", done_at, 7);
        chk("zero_nd", nd, 1);
        chk("zero_busy0", busy_at[0], 0);
        chk("zero_busy1", busy_at[1], 1);
        chk("zero_busy8", busy_at[8], 0);
        chk("zero_rdy8", rdy_at[8], 1);
        chk("zero_rd1", rd_at[1], 0);
        chk("zero_rd2", rd_at[2], 1);
        chk("zero_rd3", rd_at[3], 2);
        chk("zero_rd4", rd_at[4], 3);
        chk("zero_rd5", rd_at[5], 3);
        chk("zero_rd6", rd_at[6], 3);
        chk("zero_row6", row_at[6], 3);

        // impulse cur[1]=4096: lap -1024/+256, t = lap + 2C
        preload(1, 18'sd4096);
        run_step(0, 0, 1'b0);
        chk("imp_nw", nw, 4);
        chk("imp_cur0", wc[0], 256);
        chk("imp_cur1", wc[1], 7168);
        chk("imp_cur2", wc[2], 256);
        chk("imp_cur3", wc[3], 0);
        chk("imp_prev0", wp[0], 0);
        chk("imp_prev1", wp[1], 4096);
        chk("imp_prev2", wp[2], 0);
        chk("imp_mid_u", mid_u, 256);
        chk("imp_bank1", cur_mem[1], 7168);
        chk("imp_bank_prev1", prev_mem[1], 4096);

        // impulse at the last row: U must be clamped to 0
        preload(3, 18'sd4096);
        run_step(0, 0, 1'b0);
        chk("edge_cur0", wc[0], 0);
        chk("edge_cur2", wc[2], 256);
        chk("edge_cur3", wc[3], 7168);
        chk("edge_mid_u", mid_u, 256);

        // neighbour columns only: (160+160)>>>4 = 20 everywhere
        preload(0, 18'sd0);
        left_u  = 18'sd160;
        right_u = 18'sd160;
        run_step(0, 0, 1'b0);
        left_u  = '0;
        right_u = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lr_cur%0d", i), wc[i], 20);
        end
        chk("lr_mid_u", mid_u, 20);

        // step_start while busy is ignored
        preload(0, 18'sd0);
        run_step(3, 0, 1'b0);
        chk("rep_nd", nd, 1);
        chk("rep_nw", nw, 4);
        chk("rep_done_at", done_at, 7);
        chk("rep_busy9", busy_at[9], 0);

        // step_start wins over a same-cycle init write
        preload(0, 18'sd0);
        run_step(0, 0, 1'b1);
        chk("pri_wr0", wr_at[0], 0);
        chk("pri_nw", nw, 4);
        chk("pri_addr0", wa[0], 0);
        chk("pri_addr3", wa[3], 3);
        chk("pri_cur3", wc[3], 0);
        chk("pri_done_at", done_at, 7);
        chk("pri_bank3", cur_mem[3], 0);

        // rst during row 1: back to IDLE, no write, no done
        preload(1, 18'sd4096);
        run_step(0, 3, 1'b0);
        chk("abort_row4", row_at[4], 1);
        chk("abort_busy5", busy_at[5], 0);
        chk("abort_wr5", wr_at[5], 0);
        chk("abort_rdy5", rdy_at[5], 1);
        chk("abort_row5", row_at[5], 0);
        chk("abort_nw", nw, 2);
        chk("abort_nd", nd, 0);
        chk("abort_done_at", done_at, -1);
        chk("abort_mid_u", mid_u, 0);

        // C=131071: lap=-32768, t=229374 wraps to -32770,
        // -32770>>>13 = -5, so next = -32765 (no clamp to +131071)
        preload(1, 18'sd131071);
        run_step(0, 0, 1'b0);
        chk("wrap_cur0", wc[0], 8191);
        chk("wrap_cur1", wc[1], -32765);
        chk("wrap_cur2", wc[2], 8191);
        chk("wrap_cur3", wc[3], 0);
        chk("wrap_prev1", wp[1], 131071);
        chk("wrap_mid_u", mid_u, 8191);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
